// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared states, store map and byte counts for the TPU controller
package tpu_pkg;

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        CLEAR   = 3'd1,
        COMPUTE = 3'd2,
        CAPTURE = 3'd3,
        OUTPUT  = 3'd4
    } tpu_state_t;

    localparam logic [2:0] WEIGHT_BASE = 3'd0;
    localparam logic [2:0] INPUT_BASE  = 3'd4;
    localparam logic [2:0] LAST_ADDR   = 3'd7;

    localparam int NUM_WEIGHT_BYTES = 4;
    localparam int NUM_INPUT_BYTES  = 4;
    localparam int NUM_OUT_BYTES    = 8;
    localparam logic [2:0] LAST_OUT = 3'(NUM_OUT_BYTES - 1);

    // Store address of the cnt-th byte of a frame; weight-reuse frames start at the inputs.
    function automatic logic [2:0] load_addr(input logic keep, input logic [2:0] cnt);
        return (keep ? INPUT_BASE : WEIGHT_BASE) + cnt;
    endfunction

endpackage

// File: rtl/tpu_controller_if.sv
// rtl/tpu_controller_if.sv - host, operand store, MMU and result signals of the TPU controller
interface tpu_controller_if #(
    parameter int RES_W = 16
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             cfg_keep_weights;
    logic             mem_load_en;
    logic [2:0]       mem_addr;
    logic [7:0]       mem_data;
    logic             mmu_clear;
    logic             mmu_en;
    logic [RES_W-1:0] res0;
    logic [RES_W-1:0] res1;
    logic [RES_W-1:0] res2;
    logic [RES_W-1:0] res3;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready;
    logic             busy;
    logic             frame_done;

    modport master (
        input  in_valid, in_data, cfg_keep_weights, res0, res1, res2, res3, out_ready,
        output in_ready, mem_load_en, mem_addr, mem_data, mmu_clear, mmu_en,
               out_valid, out_data, busy, frame_done
    );

    modport slave (
        output in_valid, in_data, cfg_keep_weights, res0, res1, res2, res3, out_ready,
        input  in_ready, mem_load_en, mem_addr, mem_data, mmu_clear, mmu_en,
               out_valid, out_data, busy, frame_done
    );
endinterface

// File: rtl/tpu_controller.sv
// rtl/tpu_controller.sv - frame sequencer: load operands, run MMU, serialize results
module tpu_controller
    import tpu_pkg::*;
#(
    parameter int COMPUTE_CYCLES = 4,
    parameter int RES_W          = 16
) (
    input  logic         clk,
    input  logic         rst,
    tpu_controller_if.master bus
);

    localparam int CYC_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(COMPUTE_CYCLES - 1);

    tpu_state_t       state_q, state_d;
    logic [2:0]       load_cnt_q;
    logic             keep_q;
    logic [CYC_W-1:0] cyc_q;
    logic [2:0]       out_cnt_q;
    logic [63:0]      res_buf_q;

    logic [RES_W-1:0] res_w [4];
    logic             keep_eff;
    logic [2:0]       cur_addr;
    logic             in_hs;
    logic             out_hs;

    assign res_w[0] = bus.res0;
    assign res_w[1] = bus.res1;
    assign res_w[2] = bus.res2;
    assign res_w[3] = bus.res3;

    // The weight-reuse flag is live on the first byte and latched for the remainder.
    assign keep_eff = (load_cnt_q == 3'd0) ? bus.cfg_keep_weights : keep_q;
    assign cur_addr = load_addr(keep_eff, load_cnt_q);
    assign in_hs    = (state_q == LOAD) && bus.in_valid;
    assign out_hs   = (state_q == OUTPUT) && bus.out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_hs && cur_addr == LAST_ADDR) state_d = CLEAR;
            CLEAR:   state_d = COMPUTE;
            COMPUTE: if (cyc_q == CYC_LAST) state_d = CAPTURE;
            CAPTURE: state_d = OUTPUT;
            OUTPUT:  if (out_hs && out_cnt_q == LAST_OUT) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Load/compute/output counters, frame flag and result buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q <= 3'd0;
            keep_q     <= 1'b0;
            cyc_q      <= '0;
            out_cnt_q  <= 3'd0;
            res_buf_q  <= '0;
        end else begin
            if (in_hs) begin
                if (load_cnt_q == 3'd0) keep_q <= bus.cfg_keep_weights;
                load_cnt_q <= (cur_addr == LAST_ADDR) ? 3'd0 : load_cnt_q + 3'd1;
            end
            if (state_q == COMPUTE) begin
                cyc_q <= (cyc_q == CYC_LAST) ? '0 : cyc_q + 1'b1;
            end
            if (state_q == CAPTURE) begin
                res_buf_q <= {res_w[3][15:0], res_w[2][15:0], res_w[1][15:0], res_w[0][15:0]};
            end
            if (out_hs) out_cnt_q <= out_cnt_q + 3'd1;
        end
    end

    // Outputs; reset forces the idle values regardless of the registered state.
    always_comb begin
        bus.in_ready    = 1'b0;
        bus.mem_load_en = 1'b0;
        bus.mem_addr    = 3'd0;
        bus.mem_data    = 8'd0;
        bus.mmu_clear   = 1'b0;
        bus.mmu_en      = 1'b0;
        bus.out_valid   = 1'b0;
        bus.out_data    = 8'd0;
        bus.busy        = 1'b1;
        bus.frame_done  = 1'b0;
        if (rst) begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    bus.in_ready = 1'b1;
                    bus.busy     = (load_cnt_q != 3'd0);
                    if (bus.in_valid) begin
                        bus.mem_load_en = 1'b1;
                        bus.mem_addr    = cur_addr;
                        bus.mem_data    = bus.in_data;
                    end
                end
                CLEAR:   bus.mmu_clear = 1'b1;
                COMPUTE: bus.mmu_en    = 1'b1;
                OUTPUT: begin
                    bus.out_valid  = 1'b1;
                    bus.out_data   = res_buf_q[{out_cnt_q, 3'b000} +: 8];
                    bus.frame_done = bus.out_ready && (out_cnt_q == LAST_OUT);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_controller.sv
// tb/tb_tpu_controller.sv - directed self-checking bench for tpu_controller
module tb_tpu_controller;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tpu_controller_if #(.RES_W(16)) bus ();

    tpu_controller #(.COMPUTE_CYCLES(4), .RES_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Operand store model fed by the write strobe.
    logic [7:0] store [8] = '{default: 8'h00};
    int         wr_count = 0;
    always @(negedge clk) begin
        if (bus.mem_load_en) begin
            store[bus.mem_addr] <= bus.mem_data;
            wr_count <= wr_count + 1;
        end
    end

    logic [15:0] res_v [4];

    function automatic logic [7:0] exp_byte(input int k);
        logic [15:0] w;
        w = res_v[k / 2];
        return (k % 2 == 0) ? w[7:0] : w[15:8];
    endfunction

    task automatic set_res(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        res_v[0] = a; res_v[1] = b; res_v[2] = c; res_v[3] = d;
        bus.res0 = a; bus.res1 = b; bus.res2 = c; bus.res3 = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Feeds n bytes starting at d0; keep is presented only on the first byte.
    task automatic load_bytes(input int n, input bit keep, input bit gap, input logic [7:0] d0);
        logic [2:0] exp_addr;
        for (int i = 0; i < n; i++) begin
            bus.in_valid         = 1'b1;
            bus.in_data          = d0 + 8'(i);
            bus.cfg_keep_weights = (i == 0) ? keep : ~keep;
            exp_addr = (keep ? 3'd4 : 3'd0) + 3'(i);
            @(negedge clk);
            checks++; if (bus.mem_load_en !== 1'b1) begin failures++; $display("FAIL load_en[%0d] got=%b exp=1", i, bus.mem_load_en); end
            checks++; if (bus.mem_addr !== exp_addr) begin failures++; $display("FAIL load_addr[%0d] got=%0d exp=%0d", i, bus.mem_addr, exp_addr); end
            checks++; if (bus.mem_data !== d0 + 8'(i)) begin failures++; $display("FAIL load_data[%0d] got=%h exp=%h", i, bus.mem_data, d0 + 8'(i)); end
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL load_ready[%0d] got=%b exp=1", i, bus.in_ready); end
            tick();
            if (gap && i < n - 1) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hEE;
                @(negedge clk);
                checks++; if (bus.mem_load_en !== 1'b0) begin failures++; $display("FAIL gap_load_en[%0d] got=%b exp=0", i, bus.mem_load_en); end
                checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL gap_busy[%0d] got=%b exp=1", i, bus.busy); end
                tick();
            end
        end
        bus.in_valid         = 1'b0;
        bus.cfg_keep_weights = 1'b0;
    endtask

    // Waits (bounded) for results with out_ready high and checks all eight bytes.
    task automatic drain_check(input string tag);
        int k;
        k = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && k < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                checks++; if (bus.out_data !== exp_byte(k)) begin failures++; $display("FAIL %s_byte[%0d] got=%h exp=%h", tag, k, bus.out_data, exp_byte(k)); end
                checks++; if (bus.frame_done !== (k == 7)) begin failures++; $display("FAIL %s_done[%0d] got=%b exp=%b", tag, k, bus.frame_done, k == 7); end
                k++;
            end else if (k > 0) begin
                failures++; $display("FAIL %s_gap got=out_valid0 exp=out_valid1 at byte %0d", tag, k);
            end
            tick();
        end
        checks++; if (k != 8) begin failures++; $display("FAIL %s_timeout got=%0d bytes exp=8", tag, k); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s_idle_busy got=%b exp=0", tag, bus.busy); end
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.cfg_keep_weights = 1'b0; bus.out_ready = 1'b0;
        set_res(16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        checks++; if (bus.mem_load_en !== 1'b0) begin failures++; $display("FAIL rst_load_en got=%b exp=0", bus.mem_load_en); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if ({bus.mmu_en, bus.mmu_clear, bus.frame_done} !== 3'b000) begin failures++; $display("FAIL rst_mmu got=%b exp=000", {bus.mmu_en, bus.mmu_clear, bus.frame_done}); end
        checks++; if (bus.mem_addr !== 3'd0 || bus.out_data !== 8'd0) begin failures++; $display("FAIL rst_addr_data got=%0d/%h exp=0/00", bus.mem_addr, bus.out_data); end
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL post_rst got=ready%b busy%b exp=ready1 busy0", bus.in_ready, bus.busy); end
        checks++; if (wr_count != 0) begin failures++; $display("FAIL rst_no_write got=%0d exp=0", wr_count); end
        tick();
    endtask

    task automatic test_back_to_back;
        set_res(16'h0013, 16'h0016, 16'h002B, 16'h0032);
        load_bytes(8, 1'b0, 1'b0, 8'h01);
        @(negedge clk);
        checks++; if (bus.mmu_clear !== 1'b1 || bus.mmu_en !== 1'b0) begin failures++; $display("FAIL clear got=clr%b en%b exp=clr1 en0", bus.mmu_clear, bus.mmu_en); end
        checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL clear_ctl got=ready%b busy%b exp=ready0 busy1", bus.in_ready, bus.busy); end
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (bus.mmu_en !== 1'b1 || bus.mmu_clear !== 1'b0) begin failures++; $display("FAIL compute[%0d] got=en%b clr%b exp=en1 clr0", c, bus.mmu_en, bus.mmu_clear); end
            tick();
        end
        @(negedge clk);
        checks++; if (bus.mmu_en !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL capture got=en%b ov%b exp=en0 ov0", bus.mmu_en, bus.out_valid); end
        tick();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_byte(k)) begin failures++; $display("FAIL b2b_byte[%0d] got=v%b %h exp=v1 %h", k, bus.out_valid, bus.out_data, exp_byte(k)); end
            checks++; if (bus.frame_done !== (k == 7)) begin failures++; $display("FAIL b2b_done[%0d] got=%b exp=%b", k, bus.frame_done, k == 7); end
            tick();
        end
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=r%b b%b v%b exp=r1 b0 v0", bus.in_ready, bus.busy, bus.out_valid); end
        tick();
    endtask

    task automatic test_output_stall;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int k;
        bit seen;
        bus.out_ready = 1'b0;
        set_res(16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718);
        load_bytes(8, 1'b0, 1'b0, 8'h21);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = (bus.out_valid === 1'b1);
            tick();
        end
        checks++; if (!seen) begin failures++; $display("FAIL stall_wait got=no out_valid exp=out_valid"); end
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            bus.out_ready = pat[c % 4];
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_byte(k)) begin failures++; $display("FAIL stall_byte[%0d] got=v%b %h exp=v1 %h", k, bus.out_valid, bus.out_data, exp_byte(k)); end
            checks++; if (bus.frame_done !== (pat[c % 4] && k == 7)) begin failures++; $display("FAIL stall_done[%0d] got=%b exp=%b", k, bus.frame_done, pat[c % 4] && k == 7); end
            if (pat[c % 4]) k++;
            tick();
        end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_end got=b%b v%b exp=b0 v0", bus.busy, bus.out_valid); end
        for (int a = 0; a < 8; a++) begin
            checks++; if (store[a] !== 8'h21 + 8'(a)) begin failures++; $display("FAIL store_full[%0d] got=%h exp=%h", a, store[a], 8'h21 + 8'(a)); end
        end
        tick();
    endtask

    task automatic test_keep_weights;
        set_res(16'h1111, 16'h2222, 16'h3344, 16'h5566);
        load_bytes(4, 1'b1, 1'b0, 8'h09);
        @(negedge clk);
        checks++; if (bus.mmu_clear !== 1'b1) begin failures++; $display("FAIL keep_clear got=%b exp=1", bus.mmu_clear); end
        for (int a = 0; a < 4; a++) begin
            checks++; if (store[a] !== 8'h21 + 8'(a)) begin failures++; $display("FAIL keep_weight[%0d] got=%h exp=%h", a, store[a], 8'h21 + 8'(a)); end
            checks++; if (store[a + 4] !== 8'h09 + 8'(a)) begin failures++; $display("FAIL keep_input[%0d] got=%h exp=%h", a, store[a + 4], 8'h09 + 8'(a)); end
        end
        tick();
        drain_check("keep");
    endtask

    task automatic test_reset_mid_compute;
        load_bytes(8, 1'b0, 1'b0, 8'h31);
        @(negedge clk);
        checks++; if (bus.mmu_clear !== 1'b1) begin failures++; $display("FAIL mid_clear got=%b exp=1", bus.mmu_clear); end
        tick();
        @(negedge clk);
        checks++; if (bus.mmu_en !== 1'b1) begin failures++; $display("FAIL mid_compute1 got=%b exp=1", bus.mmu_en); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.mmu_en !== 1'b0) begin failures++; $display("FAIL mid_rst_en got=%b exp=0", bus.mmu_en); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.mmu_en !== 1'b0 || bus.mmu_clear !== 1'b0) begin failures++; $display("FAIL mid_after_en got=en%b clr%b exp=en0 clr0", bus.mmu_en, bus.mmu_clear); end
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_after_ctl got=r%b b%b v%b exp=r1 b0 v0", bus.in_ready, bus.busy, bus.out_valid); end
        tick();
    endtask

    task automatic test_gapped_load;
        set_res(16'hBEEF, 16'h0102, 16'hFF00, 16'h7F80);
        load_bytes(8, 1'b0, 1'b1, 8'h41);
        @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            checks++; if (store[a] !== 8'h41 + 8'(a)) begin failures++; $display("FAIL gap_store[%0d] got=%h exp=%h", a, store[a], 8'h41 + 8'(a)); end
        end
        tick();
        drain_check("gapped");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_output_stall();
        test_keep_weights();
        test_reset_mid_compute();
        test_gapped_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
